// File: rtl/output_writeback_pkg.sv
// Shared types and address helper for the result writeback stage.
// Channel-major output tensor layout: (ch*H + y)*W + x from BASE_ADDR.
package output_writeback_pkg;

  localparam int unsigned WB_AW = 20;
  localparam int unsigned WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } wb_state_t;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic logic [WB_AW:0] calc_addr(
    input int unsigned x,
    input int unsigned y,
    input int unsigned ch,
    input int unsigned w,
    input int unsigned h,
    input int unsigned base
  );
    int unsigned a;
    a = base + (ch * h + y) * w + x;
    return a[WB_AW:0];
  endfunction

endpackage

// File: rtl/output_writeback_if.sv
// External memory write port: request valid/addr/data, grant back.
interface output_writeback_if
  import output_writeback_pkg::*;
#(
  parameter int unsigned AW = WB_AW,
  parameter int unsigned DW = WB_DW
);

  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;

  modport master (
    output we, addr, wdata,
    input  gnt
  );

  modport slave (
    input  we, addr, wdata,
    output gnt
  );

endinterface

// File: rtl/output_writeback_sync_fifo.sv
// Small circular buffer; the head entry is a flop read straight to the port.
module sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic arst_in,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A pop frees the slot a full-buffer push lands in.
  assign wr      = push_i && (!full_o || pop_i);
  assign rd      = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (rd) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/output_writeback.sv
// Captures conv results, buffers them and writes them to external memory.
module output_writeback
  import output_writeback_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned EXT_MEM_WIDTH      = WB_DW,
  parameter int unsigned EXT_MEM_HEIGHT     = 1 << WB_AW,
  parameter int unsigned FEATURE_MAP_WIDTH  = 128,
  parameter int unsigned FEATURE_MAP_HEIGHT = 128,
  parameter int unsigned OUTPUT_NB_CHANNELS = 16,
  parameter int unsigned BASE_ADDR          = 0,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                                  clk,
  input  logic                                  arst_in,
  input  logic                                  start,
  input  logic [IO_DATA_WIDTH-1:0]              out,
  input  logic                                  output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output_writeback_if.master                    mem,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int unsigned AW    = $clog2(EXT_MEM_HEIGHT);
  localparam int unsigned TOTAL =
    FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int unsigned NW    = $clog2(TOTAL + 1);

  wb_state_t     state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, empty;
  wb_entry_t     ent, head;

  assign ent.addr = AW'(calc_addr(
    32'(output_x), 32'(output_y), 32'(output_ch),
    FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, BASE_ADDR));
  assign ent.data = {
    {(EXT_MEM_WIDTH-IO_DATA_WIDTH){out[IO_DATA_WIDTH-1]}},
    out};

  assign pop = mem.we & mem.gnt;

  sync_fifo #(
    .T     (wb_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst_in (arst_in),
    .push_i  (push),
    .data_i  (ent),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign mem.we    = !empty;
  assign mem.addr  = head.addr;
  assign mem.wdata = head.data;

  assign busy     = (state_q == COLLECT) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COLLECT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (output_valid) begin
          push  = 1'b1;
          cnt_d = cnt_q + NW'(1);
        end
        if (cnt_d == NW'(TOTAL)) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Dropped results still count toward layer completion.
    if (output_valid && state_q != COLLECT) ovf_d = 1'b1;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
